biriscv_csr_wb_pipe: RTL

// - Consumer end of the CSR E1 result interface: carries CSR read/write results and early exceptions E1->E2->WB.
// - Merges late LSU faults and interrupts, then drives the csr_writeback_* interface back into the CSR unit.
// - Sits between the CSR unit and the regfile; one instance per issue slot that can execute CSR ops.

---
 rtl/biriscv_csr_wb_pipe_pkg.sv | 64 ++++++
 rtl/biriscv_csr_wb_stage.sv | 40 ++++
 rtl/biriscv_csr_wb_pipe.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/biriscv_csr_wb_pipe_pkg.sv
`default_nettype none
// ============================================================================
// biriscv_csr_wb_pipe_pkg : exception codes, class helper and stage payloads
// Revision: 1.0
// ============================================================================
package biriscv_csr_wb_pipe_pkg;

  localparam int EXCEPTION_W = 6;

  localparam logic [EXCEPTION_W-1:0] EXCEPTION_MISALIGNED_FETCH    = 6'h10;
  localparam logic [EXCEPTION_W-1:0] EXCEPTION_FAULT_FETCH         = 6'h11;
  localparam logic [EXCEPTION_W-1:0] EXCEPTION_ILLEGAL_INSTRUCTION = 6'h12;
  localparam logic [EXCEPTION_W-1:0] EXCEPTION_BREAKPOINT          = 6'h13;
  localparam logic [EXCEPTION_W-1:0] EXCEPTION_MISALIGNED_LOAD     = 6'h14;
  localparam logic [EXCEPTION_W-1:0] EXCEPTION_FAULT_LOAD          = 6'h15;
  localparam logic [EXCEPTION_W-1:0] EXCEPTION_MISALIGNED_STORE    = 6'h16;
  localparam logic [EXCEPTION_W-1:0] EXCEPTION_FAULT_STORE         = 6'h17;
  localparam logic [EXCEPTION_W-1:0] EXCEPTION_ECALL               = 6'h18;
  localparam logic [EXCEPTION_W-1:0] EXCEPTION_INTERRUPT           = 6'h20;
  localparam logic [EXCEPTION_W-1:0] EXCEPTION_ERET                = 6'h30;
  localparam logic [EXCEPTION_W-1:0] EXCEPTION_FENCE               = 6'h40;

  typedef enum logic [1:0] {
    EXC_CLASS_NONE    = 2'd0,
    EXC_CLASS_FETCH   = 2'd1,
    EXC_CLASS_LDST    = 2'd2,
    EXC_CLASS_ILLEGAL = 2'd3
  } exc_class_e;

  // Selects which source supplies tval for a committed exception code.
  function automatic exc_class_e exc_class(input logic [EXCEPTION_W-1:0] code);
    exc_class_e cls;
    cls = EXC_CLASS_NONE;
    if (code == EXCEPTION_ILLEGAL_INSTRUCTION)
      cls = EXC_CLASS_ILLEGAL;
    else if (code == EXCEPTION_MISALIGNED_FETCH || code == EXCEPTION_FAULT_FETCH)
      cls = EXC_CLASS_FETCH;
    else if (code == EXCEPTION_MISALIGNED_LOAD  || code == EXCEPTION_FAULT_LOAD ||
             code == EXCEPTION_MISALIGNED_STORE || code == EXCEPTION_FAULT_STORE)
      cls = EXC_CLASS_LDST;
    return cls;
  endfunction

  typedef struct packed {
    logic [31:0]            pc;
    logic [11:0]            waddr;
    logic [31:0]            value;
    logic                   write;
    logic [31:0]            wdata;
    logic [EXCEPTION_W-1:0] exception;
  } e2_entry_t;

  typedef struct packed {
    logic                   write;
    logic [11:0]            waddr;
    logic [31:0]            wdata;
    logic [EXCEPTION_W-1:0] exception;
    logic [31:0]            pc;
    logic [31:0]            tval;
    logic [31:0]            value;
  } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/biriscv_csr_wb_stage.sv
`default_nettype none
// ============================================================================
// biriscv_csr_wb_stage : valid/stall/kill pipeline register (kill beats stall)
// Revision: 1.0
// ============================================================================
module biriscv_csr_wb_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             stall_i,
  input  logic             kill_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // Payload is cleared on kill so a squashed slot carries no stale write/exception.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (kill_i) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (!stall_i) begin
      r_valid <= valid_i;
      r_data  <= data_i;
    end
  end

  assign valid_o = r_valid;
  assign data_o  = r_data;

endmodule
`default_nettype wire

// File: rtl/biriscv_csr_wb_pipe.sv
`default_nettype none
// ============================================================================
// biriscv_csr_wb_pipe : CSR result E1->E2->WB carrier with exception merge
// Revision: 1.0
// ============================================================================
module biriscv_csr_wb_pipe
  import biriscv_csr_wb_pipe_pkg::*;
#(
  parameter int SUPPORT_LSU_FAULT = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   e1_valid_i,
  input  logic [31:0]            e1_pc_i,
  input  logic [31:0]            e1_opcode_i,
  input  logic [31:0]            csr_result_e1_value_i,
  input  logic                   csr_result_e1_write_i,
  input  logic [31:0]            csr_result_e1_wdata_i,
  input  logic [EXCEPTION_W-1:0] csr_result_e1_exception_i,
  input  logic [EXCEPTION_W-1:0] lsu_exception_e2_i,
  input  logic [31:0]            lsu_addr_e2_i,
  input  logic                   take_interrupt_i,
  input  logic                   stall_i,
  input  logic                   flush_i,
  output logic                   csr_writeback_write_o,
  output logic [11:0]            csr_writeback_waddr_o,
  output logic [31:0]            csr_writeback_wdata_o,
  output logic [EXCEPTION_W-1:0] csr_writeback_exception_o,
  output logic [31:0]            csr_writeback_exception_pc_o,
  output logic [31:0]            csr_writeback_exception_addr_o,
  output logic [31:0]            wb_value_o,
  output logic                   wb_valid_o
);

  localparam int c_E2_W = $bits(e2_entry_t);
  localparam int c_WB_W = $bits(wb_entry_t);

  e2_entry_t              w_e1_entry;
  e2_entry_t              w_e2_entry;
  wb_entry_t              w_wb_in;
  wb_entry_t              w_wb_entry;
  logic [c_E2_W-1:0]      w_e2_data;
  logic [c_WB_W-1:0]      w_wb_data;
  logic                   w_e2_valid;
  logic                   w_wb_valid;
  logic                   w_e2_live;
  logic                   w_squash;
  logic                   w_e2_kill;
  logic [EXCEPTION_W-1:0] w_lsu_exception;
  logic [31:0]            w_lsu_addr;
  logic [EXCEPTION_W-1:0] w_e2_exception;
  logic [31:0]            w_e2_tval;
  logic                   w_unused_opcode;

  generate
    if (SUPPORT_LSU_FAULT != 0) begin : g_lsu_fault
      assign w_lsu_exception = lsu_exception_e2_i;
      assign w_lsu_addr      = lsu_addr_e2_i;
    end else begin : g_no_lsu_fault
      assign w_lsu_exception = '0;
      assign w_lsu_addr      = '0;
    end
  endgenerate

  // Only the CSR address field of the opcode travels down the pipe.
  assign w_unused_opcode = ^e1_opcode_i[19:0];

  always_comb begin
    w_e1_entry           = '0;
    w_e1_entry.pc        = e1_pc_i;
    w_e1_entry.waddr     = e1_opcode_i[31:20];
    w_e1_entry.value     = csr_result_e1_value_i;
    w_e1_entry.write     = csr_result_e1_write_i;
    w_e1_entry.wdata     = csr_result_e1_wdata_i;
    w_e1_entry.exception = csr_result_e1_exception_i;
  end

  assign w_e2_entry = e2_entry_t'(w_e2_data);
  assign w_wb_entry = wb_entry_t'(w_wb_data);

  // An E2 entry being flushed never reaches WB, so it cannot raise anything.
  assign w_e2_live = w_e2_valid & ~flush_i;

  // Priority: early E1 code, then late LSU fault, then a pending interrupt.
  always_comb begin
    w_e2_exception = '0;
    if (w_e2_live) begin
      if (w_e2_entry.exception != '0)
        w_e2_exception = w_e2_entry.exception;
      else if (w_lsu_exception != '0)
        w_e2_exception = w_lsu_exception;
      else if (take_interrupt_i)
        w_e2_exception = EXCEPTION_INTERRUPT;
    end
  end

  always_comb begin
    w_e2_tval = '0;
    case (exc_class(w_e2_exception))
      EXC_CLASS_ILLEGAL: w_e2_tval = w_e2_entry.value;
      EXC_CLASS_LDST:    w_e2_tval = w_lsu_addr;
      EXC_CLASS_FETCH:   w_e2_tval = w_e2_entry.pc;
      default:           w_e2_tval = '0;
    endcase
  end

  always_comb begin
    w_wb_in           = '0;
    w_wb_in.write     = w_e2_entry.write;
    w_wb_in.waddr     = w_e2_entry.waddr;
    w_wb_in.wdata     = w_e2_entry.wdata;
    w_wb_in.exception = w_e2_exception;
    w_wb_in.pc        = w_e2_entry.pc;
    w_wb_in.tval      = w_e2_tval;
    w_wb_in.value     = w_e2_entry.value;
  end

  // An exception moving into WB squashes the younger instruction behind it.
  assign w_squash  = ~stall_i & (w_e2_exception != '0);
  assign w_e2_kill = flush_i | w_squash;

  biriscv_csr_wb_stage #(
    .WIDTH (c_E2_W)
  ) u_e2_stage (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .stall_i (stall_i),
    .kill_i  (w_e2_kill),
    .valid_i (e1_valid_i),
    .data_i  (w_e1_entry),
    .valid_o (w_e2_valid),
    .data_o  (w_e2_data)
  );

  biriscv_csr_wb_stage #(
    .WIDTH (c_WB_W)
  ) u_wb_stage (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .stall_i (stall_i),
    .kill_i  (1'b0),
    .valid_i (w_e2_live),
    .data_i  (w_wb_in),
    .valid_o (w_wb_valid),
    .data_o  (w_wb_data)
  );

  // FENCE is an exception code that still lets its CSR write (satp) commit.
  always_comb begin
    csr_writeback_write_o          = 1'b0;
    csr_writeback_waddr_o          = '0;
    csr_writeback_wdata_o          = '0;
    csr_writeback_exception_o      = '0;
    csr_writeback_exception_pc_o   = '0;
    csr_writeback_exception_addr_o = '0;
    wb_value_o                     = '0;
    wb_valid_o                     = w_wb_valid;
    if (w_wb_valid) begin
      csr_writeback_write_o          = w_wb_entry.write &
                                       ((w_wb_entry.exception == '0) ||
                                        (w_wb_entry.exception == EXCEPTION_FENCE));
      csr_writeback_waddr_o          = w_wb_entry.waddr;
      csr_writeback_wdata_o          = w_wb_entry.wdata;
      csr_writeback_exception_o      = w_wb_entry.exception;
      csr_writeback_exception_pc_o   = w_wb_entry.pc;
      csr_writeback_exception_addr_o = w_wb_entry.tval;
      wb_value_o                     = w_wb_entry.value;
    end
  end

endmodule
`default_nettype wire
